// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the decimal keypad BCD encoder.
// The encoder top and the one-hot classifier both import this package.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int NUM_DEC = 10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_EMIT     = 2'd2,
        S_RELEASE  = 2'd3
    } kp_state_t;

    // Index of the highest set key line; only meaningful when exactly one line is set.
    function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [NUM_DEC-1:0] onehot);
        logic [BCD_W-1:0] bcd;
        bcd = 4'd0;
        for (int i = 0; i < NUM_DEC; i++) begin
            if (onehot[i]) begin
                bcd = BCD_W'(i);
            end else begin
                bcd = bcd;
            end
        end
        return bcd;
    endfunction

    function automatic logic [NUM_DEC-1:0] bcd_to_onehot10(input logic [BCD_W-1:0] bcd);
        return 10'd1 << bcd;
    endfunction

endpackage

// File: rtl/onehot10_classify.sv
// Combinational classifier for ten key lines: none, single (with index) or multiple.
module onehot10_classify
    import bcd_pkg::*;
(
    input  logic [NUM_DEC-1:0] key_q,
    output logic               is_none,
    output logic               is_single,
    output logic               is_multi,
    output logic [BCD_W-1:0]   idx
);

    logic [3:0] ones_s;

    // Population count of the key lines.
    always_comb begin
        ones_s = 4'd0;
        for (int i = 0; i < NUM_DEC; i++) begin
            ones_s = ones_s + {3'd0, key_q[i]};
        end
    end

    assign is_none   = (ones_s == 4'd0);
    assign is_single = (ones_s == 4'd1);
    assign is_multi  = (ones_s > 4'd1);
    assign idx       = onehot10_to_bcd(key_q);

endmodule

// File: rtl/decimal_keypad_bcd_encoder.sv
// Debounces one-hot decimal keys, encodes each accepted press to BCD and
// shifts it into a packed multi-digit register (newest digit in the low nibble).
module decimal_keypad_bcd_encoder
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [9:0]                  key_in,
    input  logic                        clr,
    output logic                        bcd_valid,
    output logic [3:0]                  bcd_digit,
    output logic [4*DIGITS-1:0]         bcd_value,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic                        overflow,
    output logic                        multi_err
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int DC_W  = $clog2(DIGITS + 1);

    kp_state_t              state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [BCD_W-1:0]       cand_r, cand_next_s;
    logic [NUM_DEC-1:0]     key_q_r;
    logic                   multi_set_s;
    logic                   emit_s;

    logic                   bcd_valid_r;
    logic [BCD_W-1:0]       bcd_digit_r;
    logic [4*DIGITS-1:0]    bcd_value_r;
    logic [4*DIGITS-1:0]    shifted_s;
    logic [DC_W-1:0]        digit_count_r;
    logic                   overflow_r;
    logic                   multi_err_r;

    logic                   is_none_s, is_single_s, is_multi_s;
    logic [BCD_W-1:0]       idx_s;

    onehot10_classify u_classify (
        .key_q     (key_q_r),
        .is_none   (is_none_s),
        .is_single (is_single_s),
        .is_multi  (is_multi_s),
        .idx       (idx_s)
    );

    generate
        if (DIGITS == 1) begin : g_single_digit
            assign shifted_s = cand_r;
        end else begin : g_multi_digit
            assign shifted_s = {bcd_value_r[4*DIGITS-5:0], cand_r};
        end
    endgenerate

    // Input register plus FSM state, debounce counter and candidate key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q_r <= 10'd0;
            state_r <= S_IDLE;
            cnt_r   <= '0;
            cand_r  <= 4'd0;
        end else begin
            key_q_r <= key_in;
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            cand_r  <= cand_next_s;
        end
    end

    // Next-state logic; clear forces RELEASE so a held key is not re-emitted.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        cand_next_s  = cand_r;
        multi_set_s  = 1'b0;
        if (clr) begin
            state_next_s = S_RELEASE;
            cnt_next_s   = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (is_single_s) begin
                        state_next_s = S_DEBOUNCE;
                        cand_next_s  = idx_s;
                        cnt_next_s   = CNT_W'(1);
                    end else if (is_multi_s) begin
                        multi_set_s  = 1'b1;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_DEBOUNCE: begin
                    if (key_q_r == bcd_to_onehot10(cand_r)) begin
                        if (cnt_r == CNT_W'(DEBOUNCE - 1)) begin
                            state_next_s = S_EMIT;
                        end else begin
                            cnt_next_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_next_s = S_IDLE;
                        cnt_next_s   = '0;
                        multi_set_s  = is_multi_s;
                    end
                end
                S_EMIT: begin
                    state_next_s = S_RELEASE;
                    cnt_next_s   = '0;
                end
                S_RELEASE: begin
                    if (is_none_s) begin
                        if (cnt_r == CNT_W'(DEBOUNCE - 1)) begin
                            state_next_s = S_IDLE;
                            cnt_next_s   = '0;
                        end else begin
                            cnt_next_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_next_s = '0;
                    end
                end
                default: begin
                    state_next_s = S_IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    assign emit_s = (state_next_s == S_EMIT);

    // Output registers and digit accumulator, all updated on the edge entering EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_valid_r   <= 1'b0;
            bcd_digit_r   <= 4'd0;
            bcd_value_r   <= '0;
            digit_count_r <= '0;
            overflow_r    <= 1'b0;
            multi_err_r   <= 1'b0;
        end else if (clr) begin
            bcd_valid_r   <= 1'b0;
            bcd_value_r   <= '0;
            digit_count_r <= '0;
            overflow_r    <= 1'b0;
            multi_err_r   <= 1'b0;
        end else begin
            bcd_valid_r <= emit_s;
            if (emit_s) begin
                bcd_digit_r <= cand_r;
                bcd_value_r <= shifted_s;
                if (digit_count_r == DC_W'(DIGITS)) begin
                    overflow_r <= 1'b1;
                end else begin
                    digit_count_r <= digit_count_r + DC_W'(1);
                end
            end
            if (multi_set_s) begin
                multi_err_r <= 1'b1;
            end
        end
    end

    assign bcd_valid   = bcd_valid_r;
    assign bcd_digit   = bcd_digit_r;
    assign bcd_value   = bcd_value_r;
    assign digit_count = digit_count_r;
    assign overflow    = overflow_r;
    assign multi_err   = multi_err_r;

endmodule

// File: tb/tb_decimal_keypad_bcd_encoder.sv
// Directed bench for the keypad BCD encoder (DIGITS=4, DEBOUNCE=4).
module tb_decimal_keypad_bcd_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  key_in;
    logic        clr;
    logic        bcd_valid;
    logic [3:0]  bcd_digit;
    logic [15:0] bcd_value;
    logic [2:0]  digit_count;
    logic        overflow;
    logic        multi_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int base;

    decimal_keypad_bcd_encoder #(.DIGITS(4), .DEBOUNCE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .clr         (clr),
        .bcd_valid   (bcd_valid),
        .bcd_digit   (bcd_digit),
        .bcd_value   (bcd_value),
        .digit_count (digit_count),
        .overflow    (overflow),
        .multi_err   (multi_err)
    );

    always #5 clk = ~clk;

    // Count valid pulses, sampled away from the rising edge.
    always @(negedge clk) begin
        if (bcd_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [9:0] k, input int hold);
        key_in = k;
        repeat (hold) @(negedge clk);
        key_in = 10'd0;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        key_in = 10'd0;
        clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bcd_valid, 0);
        check("rst_digit", bcd_digit, 0);
        check("rst_value", bcd_value, 0);
        check("rst_count", digit_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_merr", multi_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of debouncing key 5
        base = valid_cnt;
        key_in = 10'h020;
        repeat (2) @(negedge clk);
        rst_n  = 1'b0;
        key_in = 10'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_valid", valid_cnt - base, 0);
        check("midrst_value", bcd_value, 0);

        // Key 7 held DEBOUNCE+3 cycles
        base = valid_cnt;
        press(10'h080, 7);
        check("k7_valid_cnt", valid_cnt - base, 1);
        check("k7_digit", bcd_digit, 7);
        check("k7_value", bcd_value, 16'h0007);
        check("k7_count", digit_count, 1);
        check("k7_ovf", overflow, 0);

        // Keys 1..5 into a fresh accumulator
        pulse_clr();
        check("clr_value", bcd_value, 0);
        check("clr_count", digit_count, 0);
        repeat (8) @(negedge clk);
        press(10'h002, 7);
        press(10'h004, 7);
        press(10'h008, 7);
        press(10'h010, 7);
        check("k1234_value", bcd_value, 16'h1234);
        check("k1234_count", digit_count, 4);
        check("k1234_ovf", overflow, 0);
        press(10'h020, 7);
        check("k5_value", bcd_value, 16'h2345);
        check("k5_count", digit_count, 4);
        check("k5_ovf", overflow, 1);
        check("k5_digit", bcd_digit, 5);

        // Bouncing key 3, then a stable press
        pulse_clr();
        repeat (8) @(negedge clk);
        base = valid_cnt;
        for (int r = 0; r < 3; r++) begin
            key_in = 10'h008;
            repeat (3) @(negedge clk);
            key_in = 10'd0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        check("bounce_no_valid", valid_cnt - base, 0);
        press(10'h008, 7);
        check("bounce_then_one", valid_cnt - base, 1);
        check("bounce_digit", bcd_digit, 3);
        check("bounce_value", bcd_value, 16'h0003);

        // Two keys at once
        base = valid_cnt;
        press(10'h003, 6);
        check("multi_err_set", multi_err, 1);
        check("multi_no_valid", valid_cnt - base, 0);
        pulse_clr();
        check("multi_err_clr", multi_err, 0);
        repeat (8) @(negedge clk);

        // Key 9 held across a clear
        base = valid_cnt;
        key_in = 10'h200;
        repeat (7) @(negedge clk);
        check("k9_first_emit", valid_cnt - base, 1);
        check("k9_first_value", bcd_value, 16'h0009);
        pulse_clr();
        check("k9_clr_value", bcd_value, 0);
        check("k9_clr_count", digit_count, 0);
        repeat (10) @(negedge clk);
        check("k9_no_reemit", valid_cnt - base, 1);
        key_in = 10'd0;
        repeat (8) @(negedge clk);
        press(10'h200, 7);
        check("k9_fresh_emit", valid_cnt - base, 2);
        check("k9_fresh_value", bcd_value, 16'h0009);
        check("k9_fresh_count", digit_count, 1);
        check("k9_fresh_digit", bcd_digit, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
